// File: rtl/alu_seq_unit.sv
// Registered ALU: single-cycle ops 0-12, shift-add MUL, optional restoring DIVU/REMU (`ALU_DIV_EN`).
// Latency: 1 cycle for ops 0-12, WIDTH+1 cycles for iterative ops; result held until out_ready.
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_zero,
    output logic             op_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic [3:0] OP_MUL  = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd15;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [SHW-1:0]   cnt;
    logic             accept;
    logic             start_iter;
    logic [WIDTH-1:0] single_res;
    logic             single_err;
    logic [WIDTH-1:0] mul_next;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] opa_nx;
    logic [WIDTH-1:0] opb_nx;
    logic [WIDTH-1:0] iter_res;

    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

`ifdef ALU_DIV_EN
    logic             is_div;
    logic             want_rem;
    logic [WIDTH:0]   trial;
    assign start_iter = (op >= OP_MUL);
`else
    assign start_iter = (op == OP_MUL);
`endif

    // Branch ops encode "taken" as 0 so alu_zero doubles as the taken flag.
    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (op)
            4'd0:    single_res = inp1 + inp2;
            4'd1:    single_res = inp1 - inp2;
            4'd2:    single_res = inp1 & inp2;
            4'd3:    single_res = inp1 | inp2;
            4'd4:    single_res = inp1 << shamt;
            4'd5:    single_res = inp1 >> shamt;
            4'd6:    single_res = WIDTH'(inp1 < inp2);
            4'd7:    single_res = WIDTH'(inp1 != inp2);
            4'd8:    single_res = WIDTH'(inp1 == inp2);
            4'd9:    single_res = WIDTH'(inp1 <= inp2);
            4'd10:   single_res = WIDTH'(inp1 < inp2);
            4'd11:   single_res = WIDTH'(inp1 >= inp2);
            4'd12:   single_res = WIDTH'(inp1 > inp2);
            default: single_err = 1'b1;
        endcase
    end

    assign mul_next = acc + (opb[0] ? opa : '0);

    // Iteration datapath: acc/opa/opb are multiplicand/multiplier for MUL,
    // remainder/dividend-quotient/divisor for division.
    always_comb begin
        acc_nx   = mul_next;
        opa_nx   = opa << 1;
        opb_nx   = opb >> 1;
        iter_res = mul_next;
`ifdef ALU_DIV_EN
        trial = {acc, opa[WIDTH-1]} - {1'b0, opb};
        if (is_div) begin
            opb_nx = opb;
            if (trial[WIDTH]) begin
                acc_nx = {acc[WIDTH-2:0], opa[WIDTH-1]};
                opa_nx = {opa[WIDTH-2:0], 1'b0};
            end else begin
                acc_nx = trial[WIDTH-1:0];
                opa_nx = {opa[WIDTH-2:0], 1'b1};
            end
            iter_res = want_rem ? acc_nx : opa_nx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            alu_out   <= '0;
            alu_zero  <= 1'b1;
            op_err    <= 1'b0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            cnt       <= '0;
`ifdef ALU_DIV_EN
            is_div    <= 1'b0;
            want_rem  <= 1'b0;
`endif
        end else if (accept) begin
            busy <= 1'b1;
            if (start_iter) begin
                state     <= ITER;
                out_valid <= 1'b0;
                acc       <= '0;
                opa       <= inp1;
                opb       <= inp2;
                cnt       <= '0;
`ifdef ALU_DIV_EN
                is_div    <= (op != OP_MUL);
                want_rem  <= (op == OP_REMU);
`endif
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                alu_out   <= single_res;
                alu_zero  <= (single_res == '0);
                op_err    <= single_err;
            end
        end else begin
            case (state)
                ITER: begin
                    acc <= acc_nx;
                    opa <= opa_nx;
                    opb <= opb_nx;
                    cnt <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        alu_out   <= iter_res;
                        alu_zero  <= (iter_res == '0);
                        op_err    <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
